video_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor to the fixed-mode HvSync.

---
 rtl/video_timing_gen.sv | 145 ++++++++++++++
 tb/tb_video_timing_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module  : video_timing_gen
// Brief   : Parametrised raster timing generator (counters, syncs, draw area,
//           start-of-line/frame and animate strobes) in the pixclk domain.
//           Define VTG_FRAME_COUNT_EN to add the 16-bit frame_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] CounterX,
  output logic [CW-1:0] CounterY,
  output logic          hSync,
  output logic          vSync,
  output logic          DrawArea,
  output logic          animate,
  output logic          sol,
  output logic          sof
`ifdef VTG_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Inclusive bounds keep every constant representable in CW bits even when
  // a porch is zero-width.
  localparam logic [CW-1:0] c_H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] c_V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] c_H_ACT_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] c_V_ACT_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] c_HS_FIRST    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_HS_LAST     = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] c_VS_FIRST    = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_VS_LAST     = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] c_ANIMATE_Y   = CW'(V_ACTIVE);

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_draw;
  logic          r_animate;
  logic          r_sol;
  logic          r_sof;

  logic          w_x_last;
  logic          w_y_last;
  logic [CW-1:0] w_nx;
  logic [CW-1:0] w_ny;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_draw;
  logic          w_sol;
  logic          w_sof;
  logic          w_animate;

  // Flags are decoded from the position being entered so they register in
  // the same edge as the counters that describe them.
  always_comb begin
    w_x_last  = (r_x == c_H_LAST);
    w_y_last  = (r_y == c_V_LAST);
    w_nx      = w_x_last ? '0 : r_x + CW'(1);
    w_ny      = r_y;
    if (w_x_last) begin
      w_ny = w_y_last ? '0 : r_y + CW'(1);
    end
    w_hs_act  = (w_nx >= c_HS_FIRST) && (w_nx <= c_HS_LAST);
    w_vs_act  = (w_ny >= c_VS_FIRST) && (w_ny <= c_VS_LAST);
    w_draw    = (w_nx <= c_H_ACT_LAST) && (w_ny <= c_V_ACT_LAST);
    w_sol     = (w_nx == '0);
    w_sof     = w_sol && (w_ny == '0);
    w_animate = w_sol && (w_ny == c_ANIMATE_Y);
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_x       <= c_H_LAST;
      r_y       <= c_V_LAST;
      r_hsync   <= ~HS_POL;
      r_vsync   <= ~VS_POL;
      r_draw    <= 1'b0;
      r_animate <= 1'b0;
      r_sol     <= 1'b0;
      r_sof     <= 1'b0;
    end else if (en) begin
      r_x       <= w_nx;
      r_y       <= w_ny;
      r_hsync   <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync   <= w_vs_act ? VS_POL : ~VS_POL;
      r_draw    <= w_draw;
      r_animate <= w_animate;
      r_sol     <= w_sol;
      r_sof     <= w_sof;
    end else begin
      // Paused: levels hold, strobes drop so resuming never repeats a pulse.
      r_animate <= 1'b0;
      r_sol     <= 1'b0;
      r_sof     <= 1'b0;
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= 16'd0;
    end else if (en && w_sof) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign CounterX = r_x;
  assign CounterY = r_y;
  assign hSync    = r_hsync;
  assign vSync    = r_vsync;
  assign DrawArea = r_draw;
  assign animate  = r_animate;
  assign sol      = r_sol;
  assign sof      = r_sof;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module  : tb_video_timing_gen
// Brief   : Scoreboard bench for video_timing_gen in a 16x8 raster mode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 2;
  localparam int CW       = 4;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int F_TOTAL  = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs;
    logic          vs;
    logic          da;
    logic          an;
    logic          sol;
    logic          sof;
    logic [15:0]   fc;
  } obs_t;

  logic          pixclk = 1'b0;
  logic          reset  = 1'b1;
  logic          en     = 1'b0;
  logic [CW-1:0] CounterX;
  logic [CW-1:0] CounterY;
  logic          hSync;
  logic          vSync;
  logic          DrawArea;
  logic          animate;
  logic          sol;
  logic          sof;
  logic [15:0]   w_fc;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .pixclk   (pixclk),
    .reset    (reset),
    .en       (en),
    .CounterX (CounterX),
    .CounterY (CounterY),
    .hSync    (hSync),
    .vSync    (vSync),
    .DrawArea (DrawArea),
    .animate  (animate),
    .sol      (sol),
    .sof      (sof)
`ifdef VTG_FRAME_COUNT_EN
    ,
    .frame_cnt(w_fc)
`endif
  );

`ifndef VTG_FRAME_COUNT_EN
  assign w_fc = 16'd0;
`endif

  always #5 pixclk = ~pixclk;

  obs_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  // Reference model: linear pixel index within the frame plus held levels.
  int   m_p;
  obs_t m_o;

  function automatic obs_t levels_at(input int p, input obs_t prev);
    obs_t o;
    int x, y;
    o  = prev;
    x  = p % H_TOTAL;
    y  = p / H_TOTAL;
    o.x  = CW'(x);
    o.y  = CW'(y);
    o.hs = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
    o.vs = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
    o.da = (x < H_ACTIVE) && (y < V_ACTIVE);
    return o;
  endfunction

  task automatic step(input logic en_v, input logic rst_v);
    @(negedge pixclk);
    en    = en_v;
    reset = rst_v;
    if (rst_v) begin
      m_p   = F_TOTAL - 1;
      m_o.x = CW'(H_TOTAL - 1);
      m_o.y = CW'(V_TOTAL - 1);
      m_o.hs = 1'b1;
      m_o.vs = 1'b1;
      m_o.da = 1'b0;
      m_o.an = 1'b0; m_o.sol = 1'b0; m_o.sof = 1'b0;
      m_o.fc = 16'd0;
    end else if (en_v) begin
      m_p    = (m_p + 1) % F_TOTAL;
      m_o    = levels_at(m_p, m_o);
      m_o.sol = (m_p % H_TOTAL) == 0;
      m_o.sof = (m_p == 0);
      m_o.an  = (m_p == V_ACTIVE * H_TOTAL);
`ifdef VTG_FRAME_COUNT_EN
      if (m_o.sof) m_o.fc = m_o.fc + 16'd1;
`endif
    end else begin
      m_o.an = 1'b0; m_o.sol = 1'b0; m_o.sof = 1'b0;
    end
    sb_q.push_back(m_o);
  endtask

  // Monitor: one expectation per clock, sampled just after the active edge.
  initial begin
    obs_t act, exp_o;
    forever begin
      @(posedge pixclk);
      #1;
      n_cyc++;
      if (sb_q.size() > 0) begin
        exp_o = sb_q.pop_front();
        act   = '{x: CounterX, y: CounterY, hs: hSync, vs: vSync, da: DrawArea,
                  an: animate, sol: sol, sof: sof, fc: w_fc};
        n_cmp++;
        if (act !== exp_o) begin
          n_fail++;
          $display("FAIL raster cyc=%0d act x=%0d y=%0d hs=%b vs=%b da=%b an=%b sol=%b sof=%b fc=%0d | exp x=%0d y=%0d hs=%b vs=%b da=%b an=%b sol=%b sof=%b fc=%0d",
                   n_cyc, act.x, act.y, act.hs, act.vs, act.da, act.an, act.sol, act.sof, act.fc,
                   exp_o.x, exp_o.y, exp_o.hs, exp_o.vs, exp_o.da, exp_o.an, exp_o.sol, exp_o.sof, exp_o.fc);
        end
      end
    end
  end

  initial begin
    int guard;
    m_p = F_TOTAL - 1;
    m_o = '0;

    // Reset hold, then two full frames free-running.
    repeat (3) step(1'b0, 1'b1);
    repeat (2 * F_TOTAL) step(1'b1, 1'b0);

    // Pause at (7,3) for five clocks, then resume.
    guard = 0;
    while (!(m_p == 3 * H_TOTAL + 7) && guard < F_TOTAL + 2) begin
      step(1'b1, 1'b0);
      guard++;
    end
    repeat (5) step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);

    // Reset mid-frame at (9,6), release and restart.
    guard = 0;
    while (!(m_p == 6 * H_TOTAL + 9) && guard < F_TOTAL + 2) begin
      step(1'b1, 1'b0);
      guard++;
    end
    repeat (2) step(1'b1, 1'b1);
    repeat (F_TOTAL + 4) step(1'b1, 1'b0);

    // Randomised enable with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    repeat (20) step(1'b1, 1'b0);

    @(negedge pixclk);
    @(negedge pixclk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d required=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
